// File: rtl/seven_segment_scan_driver.sv
// Time-multiplexed seven-segment scan driver. The display contents are
// double-buffered so that a frame never mixes old and new digits.

module seven_segment_scan_lane (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       commit,
    input  logic       take_live,
    input  logic [3:0] nib_in,
    input  logic       dot_in,
    input  logic       en_in,
    output logic [3:0] nib,
    output logic       dot,
    output logic       en,
    output logic [7:0] seg
);
    logic [3:0] pend_nib;
    logic       pend_dot;
    logic       pend_en;
    logic [6:0] hex;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_nib <= '0;
            pend_dot <= 1'b0;
            pend_en  <= 1'b0;
        end else if (load) begin
            pend_nib <= nib_in;
            pend_dot <= dot_in;
            pend_en  <= en_in;
        end
    end

    // A load in the very last frame cycle bypasses the pending copy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nib <= '0;
            dot <= 1'b0;
            en  <= 1'b0;
        end else if (commit) begin
            nib <= take_live ? nib_in : pend_nib;
            dot <= take_live ? dot_in : pend_dot;
            en  <= take_live ? en_in  : pend_en;
        end
    end

    always_comb begin
        hex = 7'b0000000;
        case (nib)
            4'h0: hex = 7'b1111110;
            4'h1: hex = 7'b0110000;
            4'h2: hex = 7'b1101101;
            4'h3: hex = 7'b1111001;
            4'h4: hex = 7'b0110011;
            4'h5: hex = 7'b1011011;
            4'h6: hex = 7'b1011111;
            4'h7: hex = 7'b1110000;
            4'h8: hex = 7'b1111111;
            4'h9: hex = 7'b1111011;
            4'hA: hex = 7'b1110111;
            4'hB: hex = 7'b0011111;
            4'hC: hex = 7'b1001110;
            4'hD: hex = 7'b0111101;
            4'hE: hex = 7'b1001111;
            4'hF: hex = 7'b1000111;
            default: hex = 7'b0000000;
        endcase
    end

    assign seg = {hex, dot};
endmodule

module seven_segment_scan_driver #(
    parameter int clk_mhz     = 50,
    parameter int w_digit     = 6,
    parameter int slot_cycles = clk_mhz * 1000,
    parameter int dead_cycles = clk_mhz
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [w_digit*4-1:0]   number,
    input  logic [w_digit-1:0]     dots,
    input  logic [w_digit-1:0]     enable,
    input  logic                   lz_suppress,
    input  logic                   load,
    output logic [7:0]             abcdefgh,
    output logic [w_digit-1:0]     digit,
    output logic                   frame_start
);
    localparam int SW = (slot_cycles > 1) ? $clog2(slot_cycles) : 1;
    localparam int IW = (w_digit > 1) ? $clog2(w_digit) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(slot_cycles - 1);
    localparam logic [SW-1:0] DEAD      = SW'(dead_cycles);
    localparam logic [IW-1:0] IDX_LAST  = IW'(w_digit - 1);

    logic [SW-1:0] slot_cnt;
    logic [IW-1:0] idx;
    logic          slot_end;
    logic          frame_end;
    logic          pending;
    logic          commit;

    logic [w_digit-1:0][3:0] lane_nib;
    logic [w_digit-1:0][7:0] lane_seg;
    logic [w_digit-1:0]      lane_dot;
    logic [w_digit-1:0]      lane_en;
    logic [w_digit-1:0]      lane_sup;
    logic [w_digit:1]        hi_zero;

    logic [7:0]         seg_nx;
    logic [w_digit-1:0] digit_nx;

    assign slot_end  = (slot_cnt == SLOT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);
    assign commit    = frame_end && (load || pending);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_cnt <= '0;
            idx      <= '0;
        end else if (slot_end) begin
            slot_cnt <= '0;
            idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            slot_cnt <= slot_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           pending <= 1'b0;
        else if (frame_end) pending <= 1'b0;
        else if (load)      pending <= 1'b1;
    end

    genvar i;
    generate
        for (i = 0; i < w_digit; i++) begin : g_lane
            seven_segment_scan_lane u_lane (
                .clk       (clk),
                .rst       (rst),
                .load      (load),
                .commit    (commit),
                .take_live (load),
                .nib_in    (number[i*4 +: 4]),
                .dot_in    (dots[i]),
                .en_in     (enable[i]),
                .nib       (lane_nib[i]),
                .dot       (lane_dot[i]),
                .en        (lane_en[i]),
                .seg       (lane_seg[i])
            );
        end

        // hi_zero[i]: nibble i and everything above it are zero.
        assign hi_zero[w_digit] = 1'b1;
        assign lane_sup[0]      = 1'b0;
        for (i = 1; i < w_digit; i++) begin : g_lz
            if (i < w_digit - 1) begin : g_mid
                assign hi_zero[i] = (lane_nib[i] == 4'h0) && hi_zero[i+1];
            end else begin : g_top
                assign hi_zero[i] = (lane_nib[i] == 4'h0);
            end
            assign lane_sup[i] = lz_suppress && hi_zero[i] && !lane_dot[i];
        end
    endgenerate

    always_comb begin
        seg_nx   = '0;
        digit_nx = '0;
        for (int k = 0; k < w_digit; k++) begin
            if (idx == IW'(k) && slot_cnt >= DEAD && lane_en[k] && !lane_sup[k]) begin
                seg_nx      = lane_seg[k];
                digit_nx[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            abcdefgh    <= '0;
            digit       <= '0;
            frame_start <= 1'b0;
        end else begin
            abcdefgh    <= seg_nx;
            digit       <= digit_nx;
            frame_start <= (slot_cnt == '0) && (idx == '0);
        end
    end
endmodule

// File: tb/tb_seven_segment_scan_driver.sv
module tb_seven_segment_scan_driver;
    localparam int NDIG  = 4;
    localparam int SLOT  = 8;
    localparam int DEAD  = 2;
    localparam int FRAME = NDIG * SLOT;

    localparam logic [6:0] HEX [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [15:0]     number = '0;
    logic [NDIG-1:0] dots = '0;
    logic [NDIG-1:0] enable = '0;
    logic            lz_suppress = 1'b0;
    logic            load = 1'b0;
    logic [7:0]      abcdefgh;
    logic [NDIG-1:0] digit;
    logic            frame_start;

    seven_segment_scan_driver #(
        .clk_mhz(1), .w_digit(NDIG), .slot_cycles(SLOT), .dead_cycles(DEAD)
    ) dut (
        .clk(clk), .rst(rst), .number(number), .dots(dots), .enable(enable),
        .lz_suppress(lz_suppress), .load(load), .abcdefgh(abcdefgh),
        .digit(digit), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int              tag;
        logic [NDIG-1:0] digit;
        logic [7:0]      seg;
        logic            fs;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int failures = 0;

    int              pos = 0;
    logic [15:0]     d_num = '0, p_num = '0;
    logic [NDIG-1:0] d_dot = '0, d_en = '0, p_dot = '0, p_en = '0;
    bit              pflag = 0;

    function automatic bit suppressed(input int d);
        return lz_suppress && d > 0 && !d_dot[d] && ((d_num >> (4 * d)) == 16'h0);
    endfunction

    task automatic model_step();
        exp_t e;
        int s, d;
        e.tag = cyc + 1;
        e.digit = '0;
        e.seg = '0;
        e.fs = 1'b0;
        if (!rst) begin
            pos = 0; pflag = 0;
            d_num = '0; d_dot = '0; d_en = '0;
            p_num = '0; p_dot = '0; p_en = '0;
        end else begin
            s = pos % SLOT;
            d = (pos / SLOT) % NDIG;
            e.fs = (pos % FRAME == 0);
            if (s >= DEAD && d_en[d] && !suppressed(d)) begin
                e.digit = NDIG'(1 << d);
                e.seg = {HEX[(d_num >> (4 * d)) & 16'hF], d_dot[d]};
            end
            if (pos % FRAME == FRAME - 1) begin
                if (load) begin
                    d_num = number; d_dot = dots; d_en = enable;
                end else if (pflag) begin
                    d_num = p_num; d_dot = p_dot; d_en = p_en;
                end
                pflag = 0;
            end else if (load) begin
                p_num = number; p_dot = dots; p_en = enable; pflag = 1;
            end
            pos++;
        end
        q.push_back(e);
    endtask

    task automatic tick(input logic ld);
        load = ld;
        model_step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].tag < cyc) begin
            e = q.pop_front();
            checks++;
            failures++;
            $display("FAIL stale_expect tag=%0d cyc=%0d", e.tag, cyc);
        end
        if (q.size() > 0 && q[0].tag == cyc) begin
            e = q.pop_front();
            checks++;
            if (digit !== e.digit || abcdefgh !== e.seg || frame_start !== e.fs) begin
                failures++;
                $display("FAIL scan cyc=%0d got digit=%b seg=%b fs=%b expected digit=%b seg=%b fs=%b",
                         cyc, digit, abcdefgh, frame_start, e.digit, e.seg, e.fs);
            end
        end
    end

    initial begin
        exp_t z;
        @(posedge clk);
        #1;
        repeat (5) tick(1'b0);
        rst = 1'b1;
        repeat (70) tick(1'b0);
        rst = 1'b0;
        repeat (3) tick(1'b0);
        rst = 1'b1;

        number = 16'h12AF; enable = 4'hF; dots = 4'h0; lz_suppress = 1'b0;
        tick(1'b1);
        repeat (70) tick(1'b0);

        number = 16'h0050; lz_suppress = 1'b1;
        tick(1'b1);
        repeat (70) tick(1'b0);
        dots = 4'b1000;
        tick(1'b1);
        repeat (70) tick(1'b0);

        dots = 4'h0; lz_suppress = 1'b0;
        while (pos % FRAME != 10) tick(1'b0);
        number = 16'h1111; tick(1'b1);
        tick(1'b0);
        number = 16'h2222; tick(1'b1);
        repeat (70) tick(1'b0);

        while (pos % FRAME != FRAME - 1) tick(1'b0);
        number = 16'h3333; tick(1'b1);
        repeat (40) tick(1'b0);

        while (pos % FRAME != 0) tick(1'b0);
        repeat (2) tick(1'b0);
        number = 16'h4444; tick(1'b1);
        while (pos % FRAME != 2 * SLOT + 5) tick(1'b0);
        checks++;
        if (digit !== 4'b0100) begin
            failures++;
            $display("FAIL pre_reset digit=%b expected 0100", digit);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (digit !== 4'b0000) begin
            failures++;
            $display("FAIL async_reset digit=%b", digit);
        end
        checks++;
        if (abcdefgh !== 8'h00) begin
            failures++;
            $display("FAIL async_reset abcdefgh=%b", abcdefgh);
        end
        checks++;
        if (frame_start !== 1'b0) begin
            failures++;
            $display("FAIL async_reset frame_start=%b", frame_start);
        end
        q.delete();
        z.tag = cyc; z.digit = '0; z.seg = '0; z.fs = 1'b0;
        q.push_back(z);
        repeat (3) tick(1'b0);
        rst = 1'b1;
        repeat (70) tick(1'b0);

        repeat (1500) begin
            number = 16'($urandom) >> $urandom_range(0, 16);
            dots = NDIG'($urandom_range(0, 3) == 0 ? $urandom : 0);
            enable = NDIG'($urandom);
            if ($urandom_range(0, 19) == 0) lz_suppress = ~lz_suppress;
            tick($urandom_range(0, 11) == 0);
        end
        load = 1'b0;
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
